// File: rtl/lpc_host.sv
// ============================================================================
//  Module   : lpc_host
//  Purpose  : LPC bus host issuing single-byte I/O or TPM read/write cycles.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lpc_host #(
   parameter logic [3:0] START_NIBBLE = 4'b0101,
   parameter int         SYNC_TIMEOUT = 8,
   parameter int         LONG_TIMEOUT = 256
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [15:0] addr_i,
   input  logic [7:0]  wdata_i,
   output logic [7:0]  rdata_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic        lframe_n_o,
   output logic [3:0]  lad_o,
   output logic        lad_oe_o,
   input  logic [3:0]  lad_i
);

   localparam int              c_CW      = $clog2(LONG_TIMEOUT + 1);
   localparam logic [c_CW-1:0] c_SYNC_TO = c_CW'(SYNC_TIMEOUT);
   localparam logic [c_CW-1:0] c_LONG_TO = c_CW'(LONG_TIMEOUT);

   localparam logic [3:0] c_ST_IDLE   = 4'd0;
   localparam logic [3:0] c_ST_START  = 4'd1;
   localparam logic [3:0] c_ST_CYCDIR = 4'd2;
   localparam logic [3:0] c_ST_ADDR   = 4'd3;
   localparam logic [3:0] c_ST_WDATA  = 4'd4;
   localparam logic [3:0] c_ST_HTAR   = 4'd5;
   localparam logic [3:0] c_ST_SYNC   = 4'd6;
   localparam logic [3:0] c_ST_RDATA  = 4'd7;
   localparam logic [3:0] c_ST_PTAR   = 4'd8;
   localparam logic [3:0] c_ST_ABORT  = 4'd9;

   logic [3:0]      r_state;
   logic [3:0]      w_state_nxt;
   logic [1:0]      r_nib;
   logic [c_CW-1:0] r_short;
   logic [c_CW-1:0] r_long;
   logic [c_CW-1:0] w_short_inc;
   logic [c_CW-1:0] w_long_inc;
   logic            r_we;
   logic [15:0]     r_addr;
   logic [7:0]      r_wdata;
   logic [7:0]      r_rdata;
   logic            r_err_pend;
   logic            r_err;
   logic            r_done;

   assign w_short_inc = r_short + c_CW'(1);
   assign w_long_inc  = r_long + c_CW'(1);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) r_state <= c_ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE:   if (req_i) w_state_nxt = c_ST_START;
         c_ST_START:  w_state_nxt = c_ST_CYCDIR;
         c_ST_CYCDIR: w_state_nxt = c_ST_ADDR;
         c_ST_ADDR:   if (r_nib == 2'd3) w_state_nxt = r_we ? c_ST_WDATA : c_ST_HTAR;
         c_ST_WDATA:  if (r_nib == 2'd1) w_state_nxt = c_ST_HTAR;
         c_ST_HTAR:   if (r_nib == 2'd1) w_state_nxt = c_ST_SYNC;
         c_ST_SYNC: begin
            // An error SYNC on a read still runs the two data clocks.
            case (lad_i)
               4'b0000, 4'b1010: w_state_nxt = r_we ? c_ST_PTAR : c_ST_RDATA;
               4'b0110: if (w_long_inc == c_LONG_TO) w_state_nxt = c_ST_ABORT;
               default: if (w_short_inc == c_SYNC_TO) w_state_nxt = c_ST_ABORT;
            endcase
         end
         c_ST_RDATA:  if (r_nib == 2'd1) w_state_nxt = c_ST_PTAR;
         c_ST_PTAR:   if (r_nib == 2'd1) w_state_nxt = c_ST_IDLE;
         c_ST_ABORT:  if (r_nib == 2'd3) w_state_nxt = c_ST_IDLE;
         default:     w_state_nxt = c_ST_IDLE;
      endcase
   end

   always_comb begin
      lframe_n_o = 1'b1;
      lad_o      = 4'b1111;
      lad_oe_o   = 1'b0;
      case (r_state)
         c_ST_START: begin
            lframe_n_o = 1'b0;
            lad_o      = START_NIBBLE;
            lad_oe_o   = 1'b1;
         end
         c_ST_CYCDIR: begin
            lad_o    = r_we ? 4'b0010 : 4'b0000;
            lad_oe_o = 1'b1;
         end
         c_ST_ADDR: begin
            case (r_nib)
               2'd0:    lad_o = r_addr[15:12];
               2'd1:    lad_o = r_addr[11:8];
               2'd2:    lad_o = r_addr[7:4];
               default: lad_o = r_addr[3:0];
            endcase
            lad_oe_o = 1'b1;
         end
         c_ST_WDATA: begin
            lad_o    = (r_nib == 2'd0) ? r_wdata[3:0] : r_wdata[7:4];
            lad_oe_o = 1'b1;
         end
         c_ST_HTAR:  lad_oe_o = (r_nib == 2'd0);
         c_ST_ABORT: begin
            lframe_n_o = 1'b0;
            lad_oe_o   = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_nib      <= 2'd0;
         r_short    <= '0;
         r_long     <= '0;
         r_we       <= 1'b0;
         r_addr     <= 16'h0000;
         r_wdata    <= 8'h00;
         r_rdata    <= 8'h00;
         r_err_pend <= 1'b0;
         r_err      <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_nib  <= (w_state_nxt != r_state) ? 2'd0 : r_nib + 2'd1;
         r_done <= 1'b0;
         // Each wait flavour clears the other's run length.
         if (r_state == c_ST_SYNC) begin
            case (lad_i)
               4'b0110: begin
                  r_long  <= w_long_inc;
                  r_short <= '0;
               end
               4'b0101: begin
                  r_short <= w_short_inc;
                  r_long  <= '0;
               end
               4'b0000, 4'b1010: begin
               end
               default: r_short <= w_short_inc;
            endcase
         end else begin
            r_short <= '0;
            r_long  <= '0;
         end
         case (r_state)
            c_ST_IDLE: begin
               if (req_i) begin
                  r_we       <= we_i;
                  r_addr     <= addr_i;
                  r_wdata    <= wdata_i;
                  r_err_pend <= 1'b0;
                  r_err      <= 1'b0;
               end
            end
            c_ST_SYNC: begin
               if (lad_i == 4'b1010 || w_state_nxt == c_ST_ABORT) r_err_pend <= 1'b1;
            end
            c_ST_RDATA: begin
               if (r_err_pend)         r_rdata      <= 8'hFF;
               else if (r_nib == 2'd0) r_rdata[3:0] <= lad_i;
               else                    r_rdata[7:4] <= lad_i;
            end
            c_ST_PTAR: begin
               if (w_state_nxt == c_ST_IDLE) begin
                  r_done <= 1'b1;
                  r_err  <= r_err_pend;
               end
            end
            c_ST_ABORT: begin
               r_rdata <= 8'hFF;
               if (w_state_nxt == c_ST_IDLE) begin
                  r_done <= 1'b1;
                  r_err  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy_o  = (r_state != c_ST_IDLE);
   assign done_o  = r_done;
   assign err_o   = r_err;
   assign rdata_o = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_lpc_host.sv
// ============================================================================
//  Module   : tb_lpc_host
//  Purpose  : Directed scoreboard bench for lpc_host with an LPC responder model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lpc_host;

   logic        clk_i   = 1'b0;
   logic        rstn_i  = 1'b0;
   logic        req_i   = 1'b0;
   logic        we_i    = 1'b0;
   logic [15:0] addr_i  = 16'h0000;
   logic [7:0]  wdata_i = 8'h00;
   logic [3:0]  lad_i   = 4'hF;
   logic [7:0]  rdata_o;
   logic        busy_o;
   logic        done_o;
   logic        err_o;
   logic        lframe_n_o;
   logic [3:0]  lad_o;
   logic        lad_oe_o;

   int n_err    = 0;
   int n_checks = 0;

   typedef struct {
      logic       err;
      logic       chk_rd;
      logic [7:0] rd;
      int         lat;
   } exp_t;

   exp_t       sb_q[$];
   logic [3:0] resp_q[$];

   lpc_host dut (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .req_i      (req_i),
      .we_i       (we_i),
      .addr_i     (addr_i),
      .wdata_i    (wdata_i),
      .rdata_o    (rdata_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .err_o      (err_o),
      .lframe_n_o (lframe_n_o),
      .lad_o      (lad_o),
      .lad_oe_o   (lad_oe_o),
      .lad_i      (lad_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_n(input logic [3:0] v, input int n);
      for (int i = 0; i < n; i++) resp_q.push_back(v);
   endtask

   // Called on a falling edge; returns on the falling edge of the done cycle.
   task automatic txn(input string tag, input logic we, input logic [15:0] addr,
                      input logic [7:0] wd, input logic hold, input int lat,
                      input logic err, input logic chk_rd, input logic [7:0] rd,
                      input logic abort);
      logic [3:0] el [1:10];
      int         hostlen;
      int         c;
      logic       seen;
      exp_t       e;
      exp_t       got;
      hostlen = we ? 10 : 8;
      for (int i = 1; i <= 10; i++) el[i] = 4'hF;
      el[1] = 4'b0101;
      el[2] = we ? 4'b0010 : 4'b0000;
      el[3] = addr[15:12];
      el[4] = addr[11:8];
      el[5] = addr[7:4];
      el[6] = addr[3:0];
      if (we) begin
         el[7] = wd[3:0];
         el[8] = wd[7:4];
      end
      e.err = err; e.chk_rd = chk_rd; e.rd = rd; e.lat = lat;
      sb_q.push_back(e);
      req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wd;
      @(posedge clk_i);
      c = 0;
      seen = 1'b0;
      while (!seen && c < 600) begin
         @(negedge clk_i);
         c++;
         if (!hold) req_i = 1'b0;
         if (c > hostlen && resp_q.size() != 0) lad_i = resp_q.pop_front();
         else                                   lad_i = 4'hF;
         if (done_o) begin
            seen = 1'b1;
            chk({tag, "/sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
               got = sb_q.pop_front();
               chk({tag, "/latency"}, c, got.lat);
               chk({tag, "/err"}, 32'(err_o), 32'(got.err));
               if (got.chk_rd) chk({tag, "/rdata"}, 32'(rdata_o), 32'(got.rd));
            end
            chk({tag, "/idle_busy"}, 32'(busy_o), 32'd0);
            chk({tag, "/idle_lframe"}, 32'(lframe_n_o), 32'd1);
            chk({tag, "/idle_oe"}, 32'(lad_oe_o), 32'd0);
         end else begin
            chk({tag, "/busy"}, 32'(busy_o), 32'd1);
            chk({tag, "/lframe"}, 32'(lframe_n_o),
                32'(!(c == 1 || (abort && c >= lat - 4))));
            chk({tag, "/oe"}, 32'(lad_oe_o),
                32'((c < hostlen) || (abort && c >= lat - 4)));
            if (c < hostlen) chk({tag, "/lad"}, 32'(lad_o), 32'(el[c]));
         end
      end
      chk({tag, "/done_seen"}, 32'(seen), 32'd1);
   endtask

   initial begin
      int dcount;
      // Reset values
      #12;
      chk("rst/busy", 32'(busy_o), 32'd0);
      chk("rst/lframe", 32'(lframe_n_o), 32'd1);
      chk("rst/lad", 32'(lad_o), 32'hF);
      chk("rst/oe", 32'(lad_oe_o), 32'd0);
      chk("rst/done", 32'(done_o), 32'd0);
      chk("rst/err", 32'(err_o), 32'd0);
      chk("rst/rdata", 32'(rdata_o), 32'h00);
      @(negedge clk_i);
      rstn_i = 1'b1;
      @(negedge clk_i);

      // Plain write, immediate ready
      push_n(4'b0000, 1);
      txn("wr_ready", 1'b1, 16'h0F00, 8'hA5, 1'b0, 14, 1'b0, 1'b0, 8'h00, 1'b0);

      // Read with three short waits
      push_n(4'b0101, 3); push_n(4'b0000, 1); push_n(4'hC, 1); push_n(4'h3, 1);
      txn("rd_short3", 1'b0, 16'h0F18, 8'h00, 1'b0, 17, 1'b0, 1'b1, 8'h3C, 1'b0);

      // No responder: short timeout abort
      txn("rd_noresp", 1'b0, 16'h1234, 8'h00, 1'b0, 21, 1'b1, 1'b1, 8'hFF, 1'b1);
      txn("wr_noresp", 1'b1, 16'h4321, 8'h77, 1'b0, 23, 1'b1, 1'b1, 8'hFF, 1'b1);

      // Error SYNC on write; err_o must persist past the done pulse
      push_n(4'b1010, 1);
      txn("wr_errsync", 1'b1, 16'h0080, 8'h11, 1'b0, 14, 1'b1, 1'b0, 8'h00, 1'b0);
      @(negedge clk_i);
      chk("wr_errsync/done_pulse", 32'(done_o), 32'd0);
      chk("wr_errsync/err_hold", 32'(err_o), 32'd1);

      // Error SYNC on read still takes two data clocks and returns FF
      push_n(4'b1010, 1); push_n(4'h1, 1); push_n(4'h2, 1);
      txn("rd_errsync", 1'b0, 16'h0081, 8'h00, 1'b0, 14, 1'b1, 1'b1, 8'hFF, 1'b0);

      // Seven short waits is one below the abort threshold
      push_n(4'b0101, 7); push_n(4'b0000, 1); push_n(4'hA, 1); push_n(4'h5, 1);
      txn("rd_short7", 1'b0, 16'h00AA, 8'h00, 1'b0, 21, 1'b0, 1'b1, 8'h5A, 1'b0);

      // A long wait in the middle restarts the short count
      push_n(4'b0101, 7); push_n(4'b0110, 1); push_n(4'b0101, 7); push_n(4'b0000, 1);
      txn("wr_mixwait", 1'b1, 16'hBEEF, 8'hC3, 1'b0, 29, 1'b0, 1'b0, 8'h00, 1'b0);

      // Long-wait boundary: 255 then ready vs. 256 aborting
      push_n(4'b0110, 255); push_n(4'b0000, 1); push_n(4'h1, 1); push_n(4'h8, 1);
      txn("rd_long255", 1'b0, 16'h2000, 8'h00, 1'b0, 269, 1'b0, 1'b1, 8'h81, 1'b0);
      push_n(4'b0110, 256);
      txn("rd_long256", 1'b0, 16'h2001, 8'h00, 1'b0, 269, 1'b1, 1'b1, 8'hFF, 1'b1);

      // Reset during the second address clock
      req_i = 1'b1; we_i = 1'b0; addr_i = 16'h0055;
      @(posedge clk_i);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         req_i = 1'b0;
      end
      rstn_i = 1'b0;
      #1;
      chk("midrst/busy", 32'(busy_o), 32'd0);
      chk("midrst/lframe", 32'(lframe_n_o), 32'd1);
      chk("midrst/lad", 32'(lad_o), 32'hF);
      chk("midrst/oe", 32'(lad_oe_o), 32'd0);
      chk("midrst/done", 32'(done_o), 32'd0);
      chk("midrst/err", 32'(err_o), 32'd0);
      chk("midrst/rdata", 32'(rdata_o), 32'h00);
      @(negedge clk_i);
      rstn_i = 1'b1;
      dcount = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_i);
         if (done_o) dcount++;
      end
      chk("midrst/no_done", dcount, 0);
      push_n(4'b0000, 1); push_n(4'h7, 1); push_n(4'hE, 1);
      txn("midrst/rd_after", 1'b0, 16'h0055, 8'h00, 1'b0, 14, 1'b0, 1'b1, 8'hE7, 1'b0);

      // Request held high: back-to-back with one IDLE cycle between
      push_n(4'b0000, 1);
      txn("hold/wr", 1'b1, 16'h0F00, 8'hA5, 1'b1, 14, 1'b0, 1'b0, 8'h00, 1'b0);
      push_n(4'b0000, 1); push_n(4'hD, 1); push_n(4'h9, 1);
      txn("hold/rd", 1'b0, 16'h0F18, 8'h00, 1'b0, 14, 1'b0, 1'b1, 8'h9D, 1'b0);
      dcount = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         if (busy_o) dcount++;
      end
      chk("hold/no_third", dcount, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
